// File: rtl/ld_cell_pkg.sv
// Shared definitions for the load-cell conditioner: channel codes, averaging depth,
// FSM state type and the tare/saturation helper.
package ld_cell_pkg;

  localparam logic [2:0]  LFT_CHNL  = 3'd0;
  localparam logic [2:0]  RGHT_CHNL = 3'd4;
  localparam int unsigned AVG_DEPTH = 4;
  localparam logic [2:0]  FILL_FULL = 3'(AVG_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStrtL,
    StWaitL,
    StStrtR,
    StWaitR,
    StUpdt
  } cond_state_t;

  // Subtract the tare and clamp the result into 0..2047.
  function automatic logic [11:0] sat_tare(input logic [11:0] avg, input logic [11:0] tare);
    logic signed [12:0] d;
    d = $signed({1'b0, avg}) - $signed({1'b0, tare});
    if (d < 13'sd0) begin
      return 12'h000;
    end else if (d > 13'sd2047) begin
      return 12'h7FF;
    end else begin
      return d[11:0];
    end
  endfunction

endpackage

// File: rtl/ld_cell_cond_if.sv
// Conversion handshake between the load-cell conditioner (master) and the A2D block (slave).
interface ld_cell_cond_if;

  logic        strt_cnv;
  logic [2:0]  chnl;
  logic        cnv_cmplt;
  logic [11:0] res;

  modport master (
    output strt_cnv,
    output chnl,
    input  cnv_cmplt,
    input  res
  );

  modport slave (
    input  strt_cnv,
    input  chnl,
    output cnv_cmplt,
    output res
  );

endinterface

// File: rtl/ld_avg4.sv
// Four-sample moving average for one load-cell channel: circular sample store plus a
// running sum that is corrected by the sample being overwritten.
module ld_avg4
  import ld_cell_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [11:0] din,
  input  logic [1:0]  wptr,
  output logic [11:0] avg
);

  logic [11:0] smpl_q [AVG_DEPTH];
  logic [13:0] sum_q;
  logic [13:0] sum_d;

  always_comb begin
    sum_d = sum_q + 14'(din) - 14'(smpl_q[wptr]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        smpl_q[i] <= '0;
      end
      sum_q <= '0;
    end else if (wr_en) begin
      smpl_q[wptr] <= din;
      sum_q        <= sum_d;
    end
  end

  assign avg = sum_q[13:2];

endmodule

// File: rtl/ld_cell_cond.sv
// Load-cell conditioner: schedules left/right A2D conversions each interval, averages
// four pairs per channel and presents tared, saturated loads with a ready pulse.
module ld_cell_cond
  import ld_cell_pkg::*;
#(
  parameter logic [19:0] SMPL_INTVL = 20'd1_000_000,
  parameter bit          fast_sim   = 1'b0,
  parameter logic [15:0] TMO_CYC    = 16'd4096,
  parameter logic [11:0] TARE       = 12'h000
) (
  input  logic                clk,
  input  logic                rst,
  ld_cell_cond_if.master      a2d,
  output logic signed [11:0]  lft_ld,
  output logic signed [11:0]  rght_ld,
  output logic                ld_vld,
  output logic                a2d_err
);

  localparam logic [19:0] IntvlFast = ((SMPL_INTVL >> 10) < 20'd32) ? 20'd32
                                                                    : (SMPL_INTVL >> 10);
  localparam logic [19:0] IntvlN    = fast_sim ? IntvlFast : SMPL_INTVL;

  cond_state_t state_q, state_d;

  logic [19:0] intvl_q, intvl_d;
  logic        wrap;
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_hit;
  logic        err_q, err_d;
  logic [11:0] lft_smp_q, lft_smp_d;
  logic [1:0]  wptr_q, wptr_d;
  logic [2:0]  fill_q, fill_d, fill_nxt;
  logic [11:0] lft_q, lft_d, rght_q, rght_d;
  logic        vld_q, vld_d;
  logic        avg_wr;
  logic        strt_cnv;
  logic [2:0]  chnl;
  logic [11:0] lft_avg, rght_avg;

  assign wrap    = (intvl_q == IntvlN - 20'd1);
  assign tmo_hit = (tmo_q == TMO_CYC - 16'd1);

  always_comb begin
    intvl_d = wrap ? 20'd0 : intvl_q + 20'd1;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    lft_smp_d = lft_smp_q;
    avg_wr    = 1'b0;
    strt_cnv  = 1'b0;
    chnl      = LFT_CHNL;
    unique case (state_q)
      StIdle: begin
        if (wrap) state_d = StStrtL;
      end
      StStrtL: begin
        strt_cnv = 1'b1;
        tmo_d    = '0;
        state_d  = StWaitL;
      end
      StWaitL: begin
        if (a2d.cnv_cmplt) begin
          lft_smp_d = a2d.res;
          state_d   = StStrtR;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StStrtR: begin
        strt_cnv = 1'b1;
        chnl     = RGHT_CHNL;
        tmo_d    = '0;
        state_d  = StWaitR;
      end
      StWaitR: begin
        chnl = RGHT_CHNL;
        // Both channels commit together so a timed-out pair leaves no trace.
        if (a2d.cnv_cmplt) begin
          avg_wr  = 1'b1;
          state_d = StUpdt;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StUpdt: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output update: registered during StUpdt, held otherwise.
  always_comb begin
    fill_nxt = (fill_q == FILL_FULL) ? fill_q : fill_q + 3'd1;
    fill_d   = fill_q;
    wptr_d   = wptr_q;
    vld_d    = 1'b0;
    lft_d    = lft_q;
    rght_d   = rght_q;
    if (state_q == StUpdt) begin
      fill_d = fill_nxt;
      wptr_d = wptr_q + 2'd1;
      if (fill_nxt == FILL_FULL) begin
        vld_d  = 1'b1;
        lft_d  = sat_tare(lft_avg, TARE);
        rght_d = sat_tare(rght_avg, TARE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      intvl_q   <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      lft_smp_q <= '0;
      wptr_q    <= '0;
      fill_q    <= '0;
      lft_q     <= '0;
      rght_q    <= '0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      intvl_q   <= intvl_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      lft_smp_q <= lft_smp_d;
      wptr_q    <= wptr_d;
      fill_q    <= fill_d;
      lft_q     <= lft_d;
      rght_q    <= rght_d;
      vld_q     <= vld_d;
    end
  end

  ld_avg4 u_avg_lft (
    .clk   (clk),
    .rst   (rst),
    .wr_en (avg_wr),
    .din   (lft_smp_q),
    .wptr  (wptr_q),
    .avg   (lft_avg)
  );

  ld_avg4 u_avg_rght (
    .clk   (clk),
    .rst   (rst),
    .wr_en (avg_wr),
    .din   (a2d.res),
    .wptr  (wptr_q),
    .avg   (rght_avg)
  );

  assign a2d.strt_cnv = strt_cnv;
  assign a2d.chnl     = chnl;
  assign lft_ld       = lft_q;
  assign rght_ld      = rght_q;
  assign ld_vld       = vld_q;
  assign a2d_err      = err_q;

endmodule
